// File: rtl/cpu_pkg.sv
// Shared execute-stage definitions: normalizer FSM encoding
// and the count-width helper used to size leading-bit counts.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } nc_state_t;

    function automatic int cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/norm_step.sv
// One binary-search step of the normalizer: tests whether the top
// s bits are leading zeros (or sign copies) and applies the shift.
module norm_step
    import cpu_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int CNT_W  = cnt_w(DATA_W)
) (
    input  logic [DATA_W-1:0] work,
    input  logic [CNT_W-1:0]  s,
    input  logic              sign,
    output logic              hit,
    output logic [DATA_W-1:0] shifted
);

    logic [DATA_W-1:0] flip;

    always_comb begin
        flip    = work;
        hit     = 1'b0;
        shifted = work;
        // CLS folds the sign into zeros so both modes become a zero test;
        // CLS also covers one extra bit, the sign bit itself.
        if (sign) begin
            flip = work ^ {DATA_W{work[DATA_W-1]}};
            hit  = (flip >> (DATA_W - 1 - int'(s))) == '0;
        end else begin
            hit  = (flip >> (DATA_W - int'(s))) == '0;
        end
        if (hit) begin
            shifted = work << s;
        end
    end

endmodule

// File: rtl/norm_counter.sv
// Iterative CLZ/CLS counter and left normalizer with valid/ready
// handshakes; one halving search step per cycle.
module norm_counter
    import cpu_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int CNT_W  = cnt_w(DATA_W),
    localparam int STEPS  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sign,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic [DATA_W-1:0] out_data,
    output logic              out_zero
);

    nc_state_t         state;
    nc_state_t         nxt;
    logic [CNT_W-1:0]  k;
    logic [CNT_W-1:0]  s;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [DATA_W-1:0] work;
    logic [DATA_W-1:0] shifted;
    logic              sign_q;
    logic              hit;
    logic              last;
    logic              in_zero;

    assign s       = CNT_W'(DATA_W >> (int'(k) + 1));
    assign last    = (k == CNT_W'(STEPS - 1));
    assign cnt_nxt = count + (hit ? s : '0);
    assign in_zero = !in_sign && (in_data == '0);

    norm_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .work    (work),
        .s       (s),
        .sign    (sign_q),
        .hit     (hit),
        .shifted (shifted)
    );

    always_comb begin
        nxt       = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    nxt = in_zero ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (last) begin
                    nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            count     <= '0;
            work      <= '0;
            sign_q    <= 1'b0;
            out_count <= '0;
            out_data  <= '0;
            out_zero  <= 1'b0;
        end else begin
            state <= nxt;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        work   <= in_data;
                        sign_q <= in_sign;
                        count  <= '0;
                        k      <= '0;
                        // All-zero CLZ needs no search.
                        if (in_zero) begin
                            out_count <= CNT_W'(DATA_W);
                            out_data  <= '0;
                            out_zero  <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    work  <= shifted;
                    count <= cnt_nxt;
                    k     <= k + 1'b1;
                    if (last) begin
                        out_count <= cnt_nxt;
                        out_data  <= shifted;
                        out_zero  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
